packet_merger_monitor: RTL and testbench
========================================

# packet_merger_monitor

Synthesizable, parametrised protocol monitor for the packet merger datapath: message input handshake, UART segment output handshake and CRC engine control. It follows each packet from message acceptance to its final UART segment, counts events, and raises sticky violation flags. It attaches passively beside the merger (instantiated or bound), drives nothing into the datapath, and its status outputs are readable by a testbench or a debug register block.

## Interface
- DATA_LENGTH, 8, UART segment width in bits
- MESSAGE_LENGTH, 48, message payload width; must be a multiple of DATA_LENGTH
- CRC_LENGTH, 8, CRC width; must be a multiple of DATA_LENGTH
- SEGMENT_COUNT, (MESSAGE_LENGTH+CRC_LENGTH)/DATA_LENGTH, UART beats per packet
- COUNTER_WIDTH, 16, width of each event counter
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- clear_errors  in  1  synchronous clear of all sticky error flags; counters unaffected
- message_valid, message_ready  in  1 each  message handshake
- message_data  in  MESSAGE_LENGTH  message payload
- uart_valid, uart_ready  in  1 each  UART segment handshake
- uart_data  in  DATA_LENGTH  segment payload
- crc_clear, crc_valid, crc_ready  in  1 each  CRC engine control
- packet_count  out  COUNTER_WIDTH  completed packets, saturating
- beat_count  out  COUNTER_WIDTH  accepted UART beats, saturating
- beat_index  out  $clog2(SEGMENT_COUNT)  current beat within the packet
- busy  out  1  high in STREAM state
- err_overlap, err_orphan_beat, err_msg_stall, err_uart_stall, err_crc_no_clear, err_payload  out  1 each  sticky flags

## Operation
- Handshake = valid && ready in the same cycle.
- States: IDLE, STREAM. Reset -> IDLE; all counters, beat_index, busy and flags at 0.
- IDLE: message handshake -> STREAM, beat_index=0, message_data captured. UART handshake -> err_orphan_beat, no other effect.
- STREAM: each UART handshake increments beat_index and beat_count. A handshake at beat_index==SEGMENT_COUNT-1 increments packet_count and returns to IDLE, beat_index=0.
- Message handshake while in STREAM before the final beat: err_overlap, recapture, beat_index=0, stay in STREAM. Message handshake in the same cycle as the final UART handshake is legal: packet_count increments, new capture, remain in STREAM.
- Stall rule, both interfaces: valid && !ready at cycle t requires valid high and data unchanged at t+1, otherwise err_msg_stall / err_uart_stall. reset at t+1 cancels the check.
- CRC rule: at least one crc_clear cycle is required between a packet's final beat (or reset) and the next message handshake; otherwise err_crc_no_clear. crc_clear in the same cycle as the message handshake satisfies the rule.
- Counters saturate at all-ones. Flags stay set until reset or clear_errors. A new violation in the same cycle as clear_errors leaves its flag set.
- Reset during STREAM aborts the packet without incrementing any count.

## Timing
- All outputs registered. A flag, counter or state change takes effect in the cycle after the causing edge (latency 1).
- Stall checks compare against a one-cycle registered copy of valid/data.
- No back-pressure; the monitor accepts every cycle.

## Configuration
- PACKET_MONITOR_PAYLOAD_CHECK_EN defined: on UART beat k < MESSAGE_LENGTH/DATA_LENGTH, uart_data must equal captured[MESSAGE_LENGTH-1-k*DATA_LENGTH -: DATA_LENGTH] (MSB segment first); a mismatch sets err_payload. CRC beats are not checked.
- Not defined: capture register and comparator are omitted, err_payload is tied to 0.

## Test plan
- Reset, then crc_clear, message 0x0123456789AB, 7 beats 01,23,45,67,89,AB,crc with ready high -> packet_count=1, beat_count=7, busy=0, all flags 0.
- UART handshake while IDLE after reset -> err_orphan_beat=1 one cycle later, beat_count=0; clear_errors -> flag 0.
- Second message handshake after 3 beats -> err_overlap=1, beat_index=0, 7 further beats -> packet_count=1.
- uart_valid=1, ready=0, data 0x45; next cycle data 0x46 -> err_uart_stall=1; same with data held -> no flag.
- Two back-to-back packets with no crc_clear between them -> err_crc_no_clear=1; final beat coincident with the next message handshake -> packet_count increments, no err_overlap.
- With PACKET_MONITOR_PAYLOAD_CHECK_EN, beat 2 sent as 0x44 instead of 0x45 -> err_payload=1; without the macro -> err_payload stays 0.

Source files
------------

// File: rtl/packet_merger_monitor.sv
// packet_merger_monitor
// Passive protocol monitor for the packet merger datapath. It follows each
// packet from message acceptance to its final UART segment, counts events
// and raises sticky violation flags. Nothing is driven back into the datapath.
//
// Optional feature macro: PACKET_MONITOR_PAYLOAD_CHECK_EN
//   defined   - the message is captured and each payload beat is compared
//               against it (MSB segment first); a mismatch sets err_payload.
//   undefined - no capture register or comparator; err_payload is tied to 0.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   clear_errors      clears all sticky flags (counters unaffected)
//   message_*         message input handshake and payload
//   uart_*            UART segment handshake and payload
//   crc_*             CRC engine control (only crc_clear is checked)
//   packet_count      completed packets, saturating
//   beat_count        accepted UART beats inside packets, saturating
//   beat_index        current beat within the packet
//   busy              high while a packet is streaming
//   err_*             sticky violation flags
module packet_merger_monitor #(
  parameter int DATA_LENGTH    = 8,
  parameter int MESSAGE_LENGTH = 48,
  parameter int CRC_LENGTH     = 8,
  parameter int SEGMENT_COUNT  = (MESSAGE_LENGTH + CRC_LENGTH) / DATA_LENGTH,
  parameter int COUNTER_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear_errors,
  input  logic                             message_valid,
  input  logic                             message_ready,
  input  logic [MESSAGE_LENGTH-1:0]        message_data,
  input  logic                             uart_valid,
  input  logic                             uart_ready,
  input  logic [DATA_LENGTH-1:0]           uart_data,
  input  logic                             crc_clear,
  input  logic                             crc_valid,
  input  logic                             crc_ready,
  output logic [COUNTER_WIDTH-1:0]         packet_count,
  output logic [COUNTER_WIDTH-1:0]         beat_count,
  output logic [$clog2(SEGMENT_COUNT)-1:0] beat_index,
  output logic                             busy,
  output logic                             err_overlap,
  output logic                             err_orphan_beat,
  output logic                             err_msg_stall,
  output logic                             err_uart_stall,
  output logic                             err_crc_no_clear,
  output logic                             err_payload
);

  localparam int IW        = $clog2(SEGMENT_COUNT);
  localparam int MSG_BEATS = MESSAGE_LENGTH / DATA_LENGTH;
  localparam logic [IW-1:0] LAST_BEAT = IW'(SEGMENT_COUNT - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t stateQ, stateD;

  logic msgHs, uartHs, finalBeat;
  logic overlapViol, orphanViol, crcViol, msgStallViol, uartStallViol;

  // Clear seen since the last final beat (or reset).
  logic crcSeen;

  // One-cycle history for the stall checks.
  logic                      msgStallQ, uartStallQ;
  logic [MESSAGE_LENGTH-1:0] msgDataQ;
  logic [DATA_LENGTH-1:0]    uartDataQ;

  // CRC engine handshake is observed but carries no rule of its own.
  logic unusedCrcHs;
  assign unusedCrcHs = crc_valid & crc_ready;

  assign msgHs     = message_valid && message_ready;
  assign uartHs    = uart_valid && uart_ready;
  assign finalBeat = (stateQ == STREAM) && uartHs && (beat_index == LAST_BEAT);

  assign overlapViol   = (stateQ == STREAM) && msgHs && !finalBeat;
  assign orphanViol    = (stateQ == IDLE) && uartHs;
  // A clear recorded before this cycle's final beat belongs to the old packet.
  assign crcViol       = msgHs && !crc_clear && !(crcSeen && !finalBeat);
  assign msgStallViol  = msgStallQ && (!message_valid || message_data != msgDataQ);
  assign uartStallViol = uartStallQ && (!uart_valid || uart_data != uartDataQ);

  assign busy = (stateQ == STREAM);

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:    if (msgHs) stateD = STREAM;
      STREAM:  if (finalBeat && !msgHs) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ           <= IDLE;
      packet_count     <= '0;
      beat_count       <= '0;
      beat_index       <= '0;
      crcSeen          <= 1'b0;
      msgStallQ        <= 1'b0;
      uartStallQ       <= 1'b0;
      msgDataQ         <= '0;
      uartDataQ        <= '0;
      err_overlap      <= 1'b0;
      err_orphan_beat  <= 1'b0;
      err_msg_stall    <= 1'b0;
      err_uart_stall   <= 1'b0;
      err_crc_no_clear <= 1'b0;
    end else begin
      stateQ <= stateD;

      if (msgHs) begin
        beat_index <= '0;
      end else if ((stateQ == STREAM) && uartHs) begin
        beat_index <= finalBeat ? '0 : beat_index + 1'b1;
      end

      if ((stateQ == STREAM) && uartHs && (beat_count != '1))
        beat_count <= beat_count + 1'b1;
      if (finalBeat && (packet_count != '1))
        packet_count <= packet_count + 1'b1;

      if (crc_clear)      crcSeen <= 1'b1;
      else if (finalBeat) crcSeen <= 1'b0;

      msgStallQ  <= message_valid && !message_ready;
      uartStallQ <= uart_valid && !uart_ready;
      msgDataQ   <= message_data;
      uartDataQ  <= uart_data;

      err_overlap      <= (err_overlap      && !clear_errors) || overlapViol;
      err_orphan_beat  <= (err_orphan_beat  && !clear_errors) || orphanViol;
      err_msg_stall    <= (err_msg_stall    && !clear_errors) || msgStallViol;
      err_uart_stall   <= (err_uart_stall   && !clear_errors) || uartStallViol;
      err_crc_no_clear <= (err_crc_no_clear && !clear_errors) || crcViol;
    end
  end

`ifdef PACKET_MONITOR_PAYLOAD_CHECK_EN
  logic [MESSAGE_LENGTH-1:0] captured;
  logic [DATA_LENGTH-1:0]    expSeg;
  logic                      payloadViol;

  // Shift form of the MSB-first segment select; only used for k < MSG_BEATS.
  assign expSeg = DATA_LENGTH'(captured >> (MESSAGE_LENGTH - (int'(beat_index) + 1) * DATA_LENGTH));
  assign payloadViol = (stateQ == STREAM) && uartHs && (int'(beat_index) < MSG_BEATS) &&
                       (uart_data != expSeg);

  always_ff @(posedge clk) begin
    if (reset) begin
      captured    <= '0;
      err_payload <= 1'b0;
    end else begin
      if (msgHs) captured <= message_data;
      err_payload <= (err_payload && !clear_errors) || payloadViol;
    end
  end
`else
  assign err_payload = 1'b0;
`endif

endmodule

// File: tb/tb_packet_merger_monitor.sv
module tb_packet_merger_monitor;

  logic        clk = 1'b0;
  logic        reset, clear_errors;
  logic        message_valid, message_ready;
  logic [47:0] message_data;
  logic        uart_valid, uart_ready;
  logic [7:0]  uart_data;
  logic        crc_clear, crc_valid, crc_ready;
  logic [15:0] packet_count, beat_count;
  logic [2:0]  beat_index;
  logic        busy;
  logic        err_overlap, err_orphan_beat, err_msg_stall;
  logic        err_uart_stall, err_crc_no_clear, err_payload;
  logic [5:0]  flags;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] F_OVL = 6'b100000;
  localparam logic [5:0] F_ORP = 6'b010000;
  localparam logic [5:0] F_MST = 6'b001000;
  localparam logic [5:0] F_UST = 6'b000100;
  localparam logic [5:0] F_CRC = 6'b000010;
  localparam logic [5:0] F_PAY = 6'b000001;
`ifdef PACKET_MONITOR_PAYLOAD_CHECK_EN
  localparam logic [5:0] PAY_EXP = F_PAY;
`else
  localparam logic [5:0] PAY_EXP = 6'b000000;
`endif

  localparam logic [47:0] MSG = 48'h0123456789AB;
  logic [7:0] beats [7] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'h5A};

  assign flags = {err_overlap, err_orphan_beat, err_msg_stall,
                  err_uart_stall, err_crc_no_clear, err_payload};

  always #5 clk = ~clk;

  packet_merger_monitor dut (
    .clk(clk), .reset(reset), .clear_errors(clear_errors),
    .message_valid(message_valid), .message_ready(message_ready), .message_data(message_data),
    .uart_valid(uart_valid), .uart_ready(uart_ready), .uart_data(uart_data),
    .crc_clear(crc_clear), .crc_valid(crc_valid), .crc_ready(crc_ready),
    .packet_count(packet_count), .beat_count(beat_count), .beat_index(beat_index),
    .busy(busy), .err_overlap(err_overlap), .err_orphan_beat(err_orphan_beat),
    .err_msg_stall(err_msg_stall), .err_uart_stall(err_uart_stall),
    .err_crc_no_clear(err_crc_no_clear), .err_payload(err_payload)
  );

  // Inputs change just after the falling edge; outputs are read there too.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_in();
    clear_errors = 0; message_valid = 0; message_ready = 0; message_data = '0;
    uart_valid = 0; uart_ready = 0; uart_data = '0;
    crc_clear = 0; crc_valid = 0; crc_ready = 0;
  endtask

  task automatic do_reset();
    idle_in(); reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic crc_clr();
    crc_clear = 1; tick(); crc_clear = 0;
  endtask

  task automatic msg(input logic [47:0] d);
    message_valid = 1; message_ready = 1; message_data = d; tick();
    message_valid = 0; message_ready = 0;
  endtask

  task automatic beat(input logic [7:0] d);
    uart_valid = 1; uart_ready = 1; uart_data = d; tick();
    uart_valid = 0; uart_ready = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (packet_count !== 16'd0) begin failures++; $display("FAIL reset_packet_count actual=%0d expected=0", packet_count); end
    checks++; if (beat_count !== 16'd0) begin failures++; $display("FAIL reset_beat_count actual=%0d expected=0", beat_count); end
    checks++; if (beat_index !== 3'd0) begin failures++; $display("FAIL reset_beat_index actual=%0d expected=0", beat_index); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", busy); end
    checks++; if (flags !== 6'b0) begin failures++; $display("FAIL reset_flags actual=%b expected=000000", flags); end
  endtask

  task automatic test_basic_packet();
    do_reset(); crc_clr(); msg(MSG);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_after_msg actual=%b expected=1", busy); end
    for (int i = 0; i < 3; i++) beat(beats[i]);
    checks++; if (beat_index !== 3'd3) begin failures++; $display("FAIL basic_beat_index actual=%0d expected=3", beat_index); end
    for (int i = 3; i < 7; i++) beat(beats[i]);
    checks++; if (packet_count !== 16'd1) begin failures++; $display("FAIL basic_packet_count actual=%0d expected=1", packet_count); end
    checks++; if (beat_count !== 16'd7) begin failures++; $display("FAIL basic_beat_count actual=%0d expected=7", beat_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end actual=%b expected=0", busy); end
    checks++; if (beat_index !== 3'd0) begin failures++; $display("FAIL basic_beat_index_end actual=%0d expected=0", beat_index); end
    checks++; if (flags !== 6'b0) begin failures++; $display("FAIL basic_flags actual=%b expected=000000", flags); end
  endtask

  task automatic test_orphan();
    do_reset(); beat(8'h11);
    checks++; if (flags !== F_ORP) begin failures++; $display("FAIL orphan_flag actual=%b expected=%b", flags, F_ORP); end
    checks++; if (beat_count !== 16'd0) begin failures++; $display("FAIL orphan_beat_count actual=%0d expected=0", beat_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL orphan_busy actual=%b expected=0", busy); end
    clear_errors = 1; tick(); clear_errors = 0;
    checks++; if (flags !== 6'b0) begin failures++; $display("FAIL orphan_cleared actual=%b expected=000000", flags); end
    // new violation coincident with clear_errors keeps the flag
    clear_errors = 1; beat(8'h22); clear_errors = 0;
    checks++; if (flags !== F_ORP) begin failures++; $display("FAIL orphan_clear_same_cycle actual=%b expected=%b", flags, F_ORP); end
  endtask

  task automatic test_overlap();
    do_reset(); crc_clr(); msg(MSG);
    for (int i = 0; i < 3; i++) beat(beats[i]);
    msg(MSG);
    checks++; if (flags !== F_OVL) begin failures++; $display("FAIL overlap_flag actual=%b expected=%b", flags, F_OVL); end
    checks++; if (beat_index !== 3'd0) begin failures++; $display("FAIL overlap_beat_index actual=%0d expected=0", beat_index); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL overlap_busy actual=%b expected=1", busy); end
    for (int i = 0; i < 7; i++) beat(beats[i]);
    checks++; if (packet_count !== 16'd1) begin failures++; $display("FAIL overlap_packet_count actual=%0d expected=1", packet_count); end
    checks++; if (beat_count !== 16'd10) begin failures++; $display("FAIL overlap_beat_count actual=%0d expected=10", beat_count); end
  endtask

  task automatic test_stall();
    do_reset();
    uart_valid = 1; uart_ready = 0; uart_data = 8'h45; tick();
    uart_data = 8'h46; tick();
    checks++; if (flags !== F_UST) begin failures++; $display("FAIL uart_stall_data actual=%b expected=%b", flags, F_UST); end
    idle_in(); do_reset();
    message_valid = 1; message_ready = 0; message_data = MSG; tick();
    message_valid = 0; tick();
    checks++; if (flags !== F_MST) begin failures++; $display("FAIL msg_stall_drop actual=%b expected=%b", flags, F_MST); end
    // reset in the cycle after a stall cancels the check
    do_reset();
    uart_valid = 1; uart_ready = 0; uart_data = 8'h45; tick();
    uart_valid = 0; reset = 1; tick(); reset = 0; tick();
    checks++; if (flags !== 6'b0) begin failures++; $display("FAIL stall_reset_cancel actual=%b expected=000000", flags); end
    // held stall resolved by ready is legal
    do_reset(); crc_clr(); msg(MSG);
    uart_valid = 1; uart_ready = 0; uart_data = beats[0]; tick();
    uart_ready = 1; tick(); uart_valid = 0; uart_ready = 0;
    checks++; if (flags !== 6'b0) begin failures++; $display("FAIL uart_stall_held actual=%b expected=000000", flags); end
    checks++; if (beat_index !== 3'd1) begin failures++; $display("FAIL uart_stall_held_index actual=%0d expected=1", beat_index); end
  endtask

  task automatic test_back_to_back();
    do_reset(); msg(MSG);
    checks++; if (flags !== F_CRC) begin failures++; $display("FAIL crc_after_reset actual=%b expected=%b", flags, F_CRC); end
    do_reset(); crc_clr(); msg(MSG);
    for (int i = 0; i < 6; i++) beat(beats[i]);
    // final beat and next message in the same cycle, no crc_clear
    uart_valid = 1; uart_ready = 1; uart_data = beats[6];
    message_valid = 1; message_ready = 1; message_data = MSG; tick();
    idle_in();
    checks++; if (flags !== F_CRC) begin failures++; $display("FAIL b2b_flags actual=%b expected=%b", flags, F_CRC); end
    checks++; if (packet_count !== 16'd1) begin failures++; $display("FAIL b2b_packet_count actual=%0d expected=1", packet_count); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy actual=%b expected=1", busy); end
    checks++; if (beat_index !== 3'd0) begin failures++; $display("FAIL b2b_beat_index actual=%0d expected=0", beat_index); end
    clear_errors = 1; tick(); clear_errors = 0;
    for (int i = 0; i < 7; i++) beat(beats[i]);
    checks++; if (packet_count !== 16'd2) begin failures++; $display("FAIL b2b_second_count actual=%0d expected=2", packet_count); end
    checks++; if (beat_count !== 16'd14) begin failures++; $display("FAIL b2b_beat_count actual=%0d expected=14", beat_count); end
    // crc_clear coincident with the message handshake satisfies the rule
    crc_clear = 1; msg(MSG); crc_clear = 0;
    checks++; if (flags !== 6'b0) begin failures++; $display("FAIL crc_same_cycle actual=%b expected=000000", flags); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL crc_same_cycle_busy actual=%b expected=1", busy); end
  endtask

  task automatic test_payload();
    do_reset(); crc_clr(); msg(MSG);
    beat(8'h01); beat(8'h23);
    checks++; if (flags !== 6'b0) begin failures++; $display("FAIL payload_good_beats actual=%b expected=000000", flags); end
    beat(8'h44);
    checks++; if (flags !== PAY_EXP) begin failures++; $display("FAIL payload_bad_beat actual=%b expected=%b", flags, PAY_EXP); end
    for (int i = 3; i < 7; i++) beat(beats[i]);
    checks++; if (packet_count !== 16'd1) begin failures++; $display("FAIL payload_packet_count actual=%0d expected=1", packet_count); end
  endtask

  initial begin
    idle_in(); reset = 1;
    test_reset();
    test_basic_packet();
    test_orphan();
    test_overlap();
    test_stall();
    test_back_to_back();
    test_payload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
